// File: rtl/alineador_palabra.sv
// Word aligner for the 10-bit serial receive path: hunts K28.5 commas, confirms a
// stable boundary, then emits aligned words with a one-cycle strobe.
module alineador_palabra #(
  parameter int         CONFIRMACIONES = 3,
  parameter int         ERRORES        = 4,
  parameter logic [9:0] COMA_NEG       = 10'h17C,
  parameter logic [9:0] COMA_POS       = 10'h283
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       entrada,
  input  logic       realinear,
  output logic [9:0] palabra,
  output logic       palabra_valida,
  output logic       bloqueado,
  output logic       coma_detectada,
  output logic [1:0] estado_dbg
);
  localparam int CW = $clog2(CONFIRMACIONES + 1);
  localparam int EW = $clog2(ERRORES + 1);
  localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRMACIONES);
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERRORES);

  typedef enum logic [1:0] {
    BUSQUEDA  = 2'd0,
    VERIFICA  = 2'd1,
    BLOQUEADO = 2'd2
  } estado_t;

  estado_t       estado, estado_sig;
  logic [9:0]    sr;
  logic [3:0]    fase, fase_sig;
  logic [CW-1:0] cnt_conf, cnt_conf_sig, conf_inc;
  logic [EW-1:0] cnt_err, cnt_err_sig, err_inc;
  logic          coma, frontera, emitir;

  assign coma       = (sr == COMA_NEG) || (sr == COMA_POS);
  assign frontera   = (fase == 4'd9);
  assign estado_dbg = estado;

  // Both counters saturate at their limits instead of wrapping.
  assign conf_inc = (cnt_conf >= CONF_MAX) ? cnt_conf : cnt_conf + CW'(1);
  assign err_inc  = (cnt_err >= ERR_MAX) ? cnt_err : cnt_err + EW'(1);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) estado <= BUSQUEDA;
    else          estado <= estado_sig;
  end

  always_comb begin
    estado_sig   = estado;
    fase_sig     = frontera ? 4'd0 : fase + 4'd1;
    cnt_conf_sig = cnt_conf;
    cnt_err_sig  = cnt_err;
    emitir       = 1'b0;
    if (realinear) begin
      estado_sig   = BUSQUEDA;
      cnt_conf_sig = '0;
      cnt_err_sig  = '0;
    end else begin
      case (estado)
        BUSQUEDA: begin
          if (coma) begin
            fase_sig     = 4'd0;
            cnt_conf_sig = CW'(1);
            cnt_err_sig  = '0;
            estado_sig   = (CONFIRMACIONES <= 1) ? BLOQUEADO : VERIFICA;
          end
        end
        VERIFICA: begin
          if (coma && frontera) begin
            cnt_conf_sig = conf_inc;
            if (conf_inc >= CONF_MAX) begin
              estado_sig  = BLOQUEADO;
              cnt_err_sig = '0;
            end
          end else if (coma) begin
            // A comma off the tentative boundary restarts confirmation at its phase.
            fase_sig     = 4'd0;
            cnt_conf_sig = CW'(1);
          end
        end
        BLOQUEADO: begin
          if (frontera) begin
            emitir = 1'b1;
            if (coma) cnt_err_sig = '0;
          end else if (coma) begin
            if (err_inc >= ERR_MAX) begin
              estado_sig   = BUSQUEDA;
              cnt_err_sig  = '0;
              cnt_conf_sig = '0;
            end else begin
              cnt_err_sig = err_inc;
            end
          end
        end
        default: estado_sig = BUSQUEDA;
      endcase
    end
  end

  // palabra_valida is a single-cycle strobe with no back-pressure: the decoder must
  // take palabra on the cycle it is high; palabra holds its value otherwise.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sr             <= '0;
      fase           <= '0;
      cnt_conf       <= '0;
      cnt_err        <= '0;
      palabra        <= '0;
      palabra_valida <= 1'b0;
      bloqueado      <= 1'b0;
      coma_detectada <= 1'b0;
    end else begin
      sr             <= {entrada, sr[9:1]};
      fase           <= fase_sig;
      cnt_conf       <= cnt_conf_sig;
      cnt_err        <= cnt_err_sig;
      palabra_valida <= emitir;
      if (emitir) palabra <= sr;
      bloqueado      <= (estado == BLOQUEADO);
      coma_detectada <= coma;
    end
  end
endmodule

// File: tb/tb_alineador_palabra.sv
// Bench for alineador_palabra: directed comma scenarios plus random bits, checked
// each cycle against an edge-count based reference of the alignment rules.
module tb_alineador_palabra;
  localparam int         CONF = 3;
  localparam int         ERRS = 4;
  localparam logic [9:0] K_NEG = 10'h17C;
  localparam logic [9:0] K_POS = 10'h283;
  localparam logic [9:0] D155  = 10'h155;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCK = 2;

  logic       clk, reset_L, entrada, realinear;
  logic [9:0] palabra;
  logic       palabra_valida, bloqueado, coma_detectada;
  logic [1:0] estado_dbg;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  bit         hist[$];
  int         n_edge = 0;
  int         anchor = 0;
  int         mode = M_HUNT;
  int         conf = 0;
  int         errs = 0;
  logic [9:0] m_pal = '0;
  logic       m_val = 1'b0, m_lock = 1'b0, m_coma = 1'b0;
  logic [9:0] exp_q[$];

  alineador_palabra dut (
    .clk(clk), .reset_L(reset_L), .entrada(entrada), .realinear(realinear),
    .palabra(palabra), .palabra_valida(palabra_valida), .bloqueado(bloqueado),
    .coma_detectada(coma_detectada), .estado_dbg(estado_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // last ten received bits, oldest in bit0
  function automatic logic [9:0] window();
    logic [9:0] w;
    w = '0;
    for (int i = 0; i < 10; i++)
      if (hist.size() > i) w[9-i] = hist[hist.size()-1-i];
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    mode = M_HUNT; conf = 0; errs = 0;
    m_pal = '0; m_val = 1'b0; m_lock = 1'b0; m_coma = 1'b0;
  endtask

  // one clock edge of the alignment rules; boundaries are every tenth edge after the anchoring comma
  task automatic model_step(input bit b, input bit rl);
    logic [9:0] w;
    bit c, bnd;
    w = window();
    c = (w == K_NEG) || (w == K_POS);
    bnd = ((n_edge - anchor) % 10) == 0;
    m_coma = c;
    m_lock = (mode == M_LOCK);
    m_val = 1'b0;
    if (rl) begin
      mode = M_HUNT; conf = 0; errs = 0;
    end else if (mode == M_HUNT) begin
      if (c) begin
        anchor = n_edge; conf = 1; errs = 0;
        mode = (CONF <= 1) ? M_LOCK : M_VERIFY;
      end
    end else if (mode == M_VERIFY) begin
      if (c && bnd) begin
        if (conf < CONF) conf++;
        if (conf >= CONF) begin mode = M_LOCK; errs = 0; end
      end else if (c) begin
        anchor = n_edge; conf = 1;
      end
    end else begin
      if (bnd) begin
        m_pal = w; m_val = 1'b1;
        exp_q.push_back(w);
        if (c) errs = 0;
      end else if (c) begin
        if (errs < ERRS) errs++;
        if (errs >= ERRS) begin mode = M_HUNT; errs = 0; conf = 0; end
      end
    end
    hist.push_back(b);
    if (hist.size() > 10) void'(hist.pop_front());
    n_edge++;
  endtask

  task automatic compare_outputs();
    check("palabra_valida", palabra_valida, m_val);
    check("bloqueado", bloqueado, m_lock);
    check("coma_detectada", coma_detectada, m_coma);
    check("palabra", palabra, m_pal);
    if (palabra_valida === 1'b1 && exp_q.size() > 0) check("sb_word", palabra, exp_q.pop_front());
  endtask

  // drivers: called at a negedge, return at the following negedge after checking
  task automatic send_bit(input bit b, input bit rl);
    entrada = b;
    realinear = rl;
    model_step(b, rl);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i], 1'b0);
  endtask

  task automatic send_fill(input int k);
    for (int i = 0; i < k; i++) send_bit(D155[i % 10], 1'b0);
  endtask

  task automatic lock_stream();
    send_word(K_NEG); send_word(K_POS); send_word(K_NEG);
    send_word(D155); send_word(D155); send_word(D155);
  endtask

  task automatic pulse_reset();
    #2 reset_L = 1'b0;
    #1;
    check("rst_palabra", palabra, 10'h000);
    check("rst_valida", palabra_valida, 1'b0);
    check("rst_bloqueado", bloqueado, 1'b0);
    check("rst_coma", coma_detectada, 1'b0);
    model_reset();
    @(negedge clk);
    compare_outputs();
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0; entrada = 1'b0; realinear = 1'b0;
    repeat (2) @(negedge clk);
    compare_outputs();
    reset_L = 1'b1;

    // back-to-back commas from reset, then data words
    lock_stream();
    check("t2_lock", bloqueado, 1'b1);
    check("t2_word", palabra, D155);

    // realinear on a boundary cycle while locked
    send_word(D155);
    send_bit(D155[0], 1'b1);
    check("t6_no_strobe", palabra_valida, 1'b0);
    send_bit(D155[1], 1'b0);
    check("t6_unlock", bloqueado, 1'b0);
    send_fill(8);
    lock_stream();
    check("t6_relock", bloqueado, 1'b1);

    // misaligned commas while locked
    send_fill(3);
    send_word(K_NEG); send_word(K_POS); send_word(K_NEG);
    check("t4_hold3", bloqueado, 1'b1);
    send_fill(7);
    send_word(K_NEG);
    send_word(D155);
    check("t4_cleared", bloqueado, 1'b1);
    send_fill(3);
    send_word(K_POS); send_word(K_NEG); send_word(K_POS); send_word(K_NEG);
    send_word(D155); send_word(D155);
    check("t4_lost", bloqueado, 1'b0);

    // random bits ahead of the lock sequence
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    lock_stream();
    check("t3_lock", bloqueado, 1'b1);
    check("t3_word", palabra, D155);

    // confirmation restart from an off-phase comma
    send_bit(1'b0, 1'b1);
    send_fill(9);
    send_word(K_NEG); send_word(K_POS);
    send_fill(5);
    send_word(K_NEG); send_word(K_POS);
    send_bit(1'b0, 1'b0);
    check("t5_restarted", bloqueado, 1'b0);
    send_fill(9);
    send_word(K_NEG); send_word(K_POS); send_word(D155); send_word(D155);
    check("t5_lock", bloqueado, 1'b1);

    // random soak: commas, arbitrary words, odd slips and realign pulses
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: for (int i = 0; i < int'($urandom_range(1, 9)); i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        1: send_word(($urandom_range(0, 1) != 0) ? K_NEG : K_POS);
        2: send_word(($urandom_range(0, 1) != 0) ? K_POS : K_NEG);
        3: send_word(10'($urandom_range(0, 1023)));
        default: send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      endcase
    end

    // asynchronous reset mid-word while locked
    send_bit(1'b0, 1'b1);
    send_fill(3);
    lock_stream();
    check("t1_locked", bloqueado, 1'b1);
    send_fill(4);
    pulse_reset();
    send_word(K_NEG); send_word(K_POS); send_word(D155);
    check("t1_not_yet", bloqueado, 1'b0);
    lock_stream();
    check("t1_relock", bloqueado, 1'b1);
    check("t1_word", palabra, D155);

    check("sb_drained", 10'(exp_q.size()), 10'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
